// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage load/store responder with a small word-addressed data memory.
// Latency: response strobe LATENCY+1 cycles after the accept cycle (1 cycle when LATENCY=0).
// Backpressure: one request in flight; req_ready low and mem_stall high until the response.
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_stall
);

  localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAT   = 4'(LATENCY);
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Power-up contents of the data memory; every word not listed starts at zero.
  function automatic logic [31:0] preload_word(input int idx);
    logic [31:0] w;
    case (idx)
      0:       w = 32'hA000_00AA;
      4:       w = 32'h1000_0011;
      8:       w = 32'h2000_0022;
      12:      w = 32'h3000_0033;
      16:      w = 32'h4000_0044;
      20:      w = 32'h5000_0055;
      24:      w = 32'h6000_0066;
      28:      w = 32'h7000_0077;
      32:      w = 32'h8000_0088;
      36:      w = 32'h9000_0099;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  // Commit-edge view of the request: the live inputs when LATENCY=0 jumps
  // straight from IDLE to RESP, otherwise the copy latched at accept.
  logic          commit;
  logic          c_we;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [AW-1:0] c_idx;
  logic          c_err;
  logic          wr_en;
  logic [31:0]   mem_rd [DEPTH];

  // Select which request the commit logic looks at.
  always_comb begin
    c_we    = we_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      c_we    = req_we;
      c_addr  = req_addr;
      c_wdata = req_wdata;
    end
  end

  assign c_idx = c_addr[AW+1:2];
  assign c_err = (c_addr[1:0] != 2'b00) || (c_addr >= LIMIT);

  // A store only lands when it commits cleanly; a reset in the same cycle drops it.
  assign wr_en = commit && c_we && !c_err && !rst;

  // Next-state, handshake and stall decode for the request FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    commit     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_stall  = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        mem_stall = req_valid;
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = LAT;
          if (LATENCY == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        mem_stall = 1'b1;
        cnt_d     = cnt_q - 4'd1;
        // <= 1 rather than == 1 so a corrupted zero count cannot wedge the FSM.
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Response payload is captured on the commit edge and held until the next one.
    if (commit) begin
      err_d   = c_err;
      rdata_d = (c_we || c_err) ? 32'h0 : mem_rd[c_idx];
    end

    if (rst) begin
      req_ready = 1'b0;
      mem_stall = 1'b0;
    end
  end

  // FSM, counter, latched request and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Data memory: one register per word so each can carry its own power-up value;
  // reset deliberately leaves the contents alone.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [31:0] word_q = preload_word(i);

    // Word write on a clean store commit addressed to this word.
    always_ff @(posedge clk) begin
      if (wr_en && (c_idx == AW'(i))) begin
        word_q <= c_wdata;
      end
    end

    assign mem_rd[i] = word_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: table vectors, directed corner sequences and
// randomized traffic against a transaction-level memory model.
// Two instances: LATENCY=2 (side A) and LATENCY=0 (side B).
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int LAT_A = 2;
  localparam int LAT_B = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_a, req_valid_b;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;

  logic        ready_a, rv_a, err_a, stall_a;
  logic [31:0] rdata_a;
  logic        ready_b, rv_b, err_b, stall_b;
  logic [31:0] rdata_b;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(ready_a), .resp_valid(rv_a), .resp_rdata(rdata_a), .resp_err(err_a),
    .mem_stall(stall_a)
  );

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_B)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(ready_b), .resp_valid(rv_b), .resp_rdata(rdata_b), .resp_err(err_b),
    .mem_stall(stall_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory image per instance, kept at transaction level.
  logic [31:0] ref_mem [2][DEPTH];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Preload rule: words 0,4,...,36 hold k in the top and bottom nibbles (k = word/4),
  // except word 0 which holds 0xA00000AA.
  function automatic logic [31:0] preload(input int w);
    logic [3:0] k;
    if ((w % 4) != 0 || w > 36) return 32'h0;
    if (w == 0) return 32'hA000_00AA;
    k = 4'(w / 4);
    return {k, 20'h0, k, k};
  endfunction

  function automatic void model_init();
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < DEPTH; w++)
        ref_mem[s][w] = preload(w);
  endfunction

  function automatic void model_access(input int s, input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata,
                                       output logic [31:0] rd, output logic er);
    er = ((addr % 4) != 0) || (addr >= 32'(4 * DEPTH));
    rd = 32'h0;
    if (!er) begin
      if (we) ref_mem[s][addr / 4] = wdata;
      else    rd = ref_mem[s][addr / 4];
    end
  endfunction

  task automatic set_valid(input int sel, input logic v);
    if (sel == 0) req_valid_a = v;
    else          req_valid_b = v;
  endtask

  task automatic sample(input int sel, output logic rdy, output logic rv, output logic st,
                        output logic er, output logic [31:0] rd);
    if (sel == 0) begin
      rdy = ready_a; rv = rv_a; st = stall_a; er = err_a; rd = rdata_a;
    end else begin
      rdy = ready_b; rv = rv_b; st = stall_b; er = err_b; rd = rdata_b;
    end
  endtask

  // One request through the handshake; checks latency, stall length, ready pattern and payload.
  task automatic txn(input int sel, input string name, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    int lat_exp, lat, stalls, rdy_bad, l;
    logic rdy, rv, st, er, er_got;
    logic [31:0] rd, rd_got;
    l = (sel == 0) ? LAT_A : LAT_B;
    lat_exp = (l > 0) ? l + 1 : 1;
    lat = -1; stalls = 0; rdy_bad = 0; rd_got = 32'h0; er_got = 1'b0;
    @(posedge clk); #1;
    req_we = we; req_addr = addr; req_wdata = wdata;
    set_valid(sel, 1'b1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      sample(sel, rdy, rv, st, er, rd);
      if (st) stalls++;
      if ((c == 0) != rdy) rdy_bad++;
      if (rv) begin
        lat = c; rd_got = rd; er_got = er;
      end
      @(posedge clk); #1;
      set_valid(sel, 1'b0);
      if (lat >= 0) break;
    end
    check({name, " latency"}, lat, lat_exp);
    check({name, " stall cycles"}, stalls, lat_exp);
    check({name, " ready pattern errors"}, rdy_bad, 0);
    check({name, " rdata"}, rd_got, exp_rd);
    check({name, " err"}, er_got, exp_err);
  endtask

  // req_valid held high: exactly one response per LATENCY+2 cycles, ready only in IDLE.
  task automatic held(input int sel, input string name, input logic [31:0] addr,
                      input logic [31:0] exp_rd, input int n_resp);
    int p;
    logic rdy, rv, st, er;
    logic [31:0] rd;
    p = ((sel == 0) ? LAT_A : LAT_B) + 2;
    @(posedge clk); #1;
    req_we = 1'b0; req_addr = addr; req_wdata = 32'h0;
    set_valid(sel, 1'b1);
    for (int c = 0; c < n_resp * p; c++) begin
      @(negedge clk);
      sample(sel, rdy, rv, st, er, rd);
      check({name, " resp_valid"}, rv, ((c % p) == p - 1));
      check({name, " req_ready"}, rdy, ((c % p) == 0));
      if (rv) check({name, " rdata"}, rd, exp_rd);
      @(posedge clk); #1;
    end
    set_valid(sel, 1'b0);
    @(negedge clk);
    sample(sel, rdy, rv, st, er, rd);
    check({name, " ready after"}, rdy, 1'b1);
    check({name, " no extra resp"}, rv, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] erd, wd, ad;
    logic        eer, we;
    int          nresp, r;

    tbl.push_back('{1'b0, 32'h0000_0010, 32'h0,         32'h1000_0011, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_008C, 32'hDEAD_BEEF, 32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h0000_008C, 32'h0,         32'hDEAD_BEEF, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0088, 32'h0,         32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h0000_0090, 32'h0,         32'h9000_0099, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0080, 32'h0,         32'h8000_0088, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0013, 32'h0,         32'h0,         1'b1});
    tbl.push_back('{1'b1, 32'h0000_0100, 32'h1122_3344, 32'h0,         1'b1});
    tbl.push_back('{1'b0, 32'h0000_0000, 32'h0,         32'hA000_00AA, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_00FC, 32'h0BAD_F00D, 32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h0000_00FC, 32'h0,         32'h0BAD_F00D, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_00FF, 32'h0,         32'h0,         1'b1});
    tbl.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1});
    tbl.push_back('{1'b1, 32'h0000_0022, 32'h5555_5555, 32'h0,         1'b1});
    tbl.push_back('{1'b0, 32'h0000_0020, 32'h0,         32'h2000_0022, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0050, 32'h0,         32'h5000_0055, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0004, 32'h0,         32'h0,         1'b0});

    model_init();
    rst = 1'b1; req_valid_a = 1'b1; req_valid_b = 1'b0;
    req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

    // Reset behaviour, with a request presented during reset to show it is ignored.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst req_ready", ready_a, 1'b0);
    check("rst mem_stall", stall_a, 1'b0);
    check("rst resp_valid", rv_a, 1'b0);
    check("rst resp_rdata", rdata_a, 32'h0);
    check("rst resp_err", err_a, 1'b0);
    req_valid_a = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post-rst req_ready", ready_a, 1'b1);
    check("post-rst mem_stall", stall_a, 1'b0);
    check("post-rst resp_valid", rv_a, 1'b0);

    // Table vectors on the LATENCY=2 instance.
    for (int i = 0; i < tbl.size(); i++) begin
      model_access(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, erd, eer);
      txn(0, $sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata,
          tbl[i].exp_rd, tbl[i].exp_err);
    end

    // Reset in the first WAIT cycle of a store: no response, store dropped.
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678; req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("midrst mem_stall", stall_a, 1'b0);
    check("midrst req_ready", ready_a, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    nresp = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) check("midrst ready after", ready_a, 1'b1);
      if (rv_a) nresp++;
    end
    check("midrst responses", nresp, 0);
    txn(0, "midrst reload", 1'b0, 32'h20, 32'h0, 32'h2000_0022, 1'b0);

    // Reset during RESP: store already committed stays committed.
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFE_F00D; req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("resprst resp_valid next", rv_a, 1'b0);
    check("resprst ready", ready_a, 1'b1);
    model_access(0, 1'b1, 32'h40, 32'hCAFE_F00D, erd, eer);
    txn(0, "resprst reload", 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0);

    // Held request across two loads.
    held(0, "heldA", 32'h30, 32'h3000_0033, 2);

    // LATENCY=0 instance.
    txn(1, "l0 load0", 1'b0, 32'h0, 32'h0, 32'hA000_00AA, 1'b0);
    model_access(1, 1'b1, 32'h44, 32'h0F0F_1234, erd, eer);
    txn(1, "l0 store", 1'b1, 32'h44, 32'h0F0F_1234, 32'h0, 1'b0);
    txn(1, "l0 reload", 1'b0, 32'h44, 32'h0, 32'h0F0F_1234, 1'b0);
    txn(1, "l0 misalign", 1'b0, 32'h45, 32'h0, 32'h0, 1'b1);
    held(1, "heldB", 32'h60, 32'h6000_0066, 3);

    // Randomized traffic against the model, biased toward a few words for reuse.
    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 9);
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      if (r < 3)      ad = 32'($urandom_range(0, 15)) * 4;
      else if (r < 6) ad = 32'($urandom_range(0, DEPTH - 1)) * 4;
      else if (r < 8) ad = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
      else if (r < 9) ad = 32'(4 * DEPTH) + 32'($urandom_range(0, 1000)) * 4;
      else            ad = $urandom;
      model_access(0, we, ad, wd, erd, eer);
      txn(0, $sformatf("rnd%0d", i), we, ad, wd, erd, eer);
    end

    // Final read-back of every word of side A against the model.
    for (int w = 0; w < DEPTH; w++) begin
      model_access(0, 1'b0, 32'(w * 4), 32'h0, erd, eer);
      txn(0, $sformatf("dump%0d", w), 1'b0, 32'(w * 4), 32'h0, erd, eer);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
